// File: rtl/analyzer_capture.sv
// Frame-stable capture of eight 64-bit probe buses for the debug hex overlay, with arm/trigger/hold freeze.
// Optional macro ANALYZER_CAPTURE_EDGE_TRIG_EN: trigger on the rising edge of the match condition instead of its level.
module analyzer_capture #(
    parameter int HOLD_FRAMES = 60,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   i_reset_n,
    input  logic                   i_vblank,
    input  logic [63:0]            i_probe0,
    input  logic [63:0]            i_probe1,
    input  logic [63:0]            i_probe2,
    input  logic [63:0]            i_probe3,
    input  logic [63:0]            i_probe4,
    input  logic [63:0]            i_probe5,
    input  logic [63:0]            i_probe6,
    input  logic [63:0]            i_probe7,
    input  logic [63:0]            i_trig_mask,
    input  logic [63:0]            i_trig_value,
    input  logic                   i_arm,
    output logic [63:0]            o_debug0,
    output logic [63:0]            o_debug1,
    output logic [63:0]            o_debug2,
    output logic [63:0]            o_debug3,
    output logic [63:0]            o_debug4,
    output logic [63:0]            o_debug5,
    output logic [63:0]            o_debug6,
    output logic [63:0]            o_debug7,
    output logic [1:0]             o_state,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

    localparam logic [1:0] ST_LIVE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_FROZEN = 2'd3;

    // Wide enough for HOLD_FRAMES plus the extra count a trigger-on-edge start can add.
    localparam int              HC_W     = $clog2(HOLD_FRAMES + 2);
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(HOLD_FRAMES);

    logic [7:0][63:0]      w_probe;
    logic [7:0][63:0]      r_debug;
    logic [7:0][63:0]      r_shadow;
    logic [1:0]            r_state;
    logic [HC_W-1:0]       r_hold_cnt;
    logic [HC_W-1:0]       w_hold_inc;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                  r_vblank_hist;
    logic                  w_fe;
    logic                  w_match;
    logic                  w_trig;

    assign w_probe = {i_probe7, i_probe6, i_probe5, i_probe4,
                      i_probe3, i_probe2, i_probe1, i_probe0};

    assign w_fe       = i_vblank & ~r_vblank_hist;
    assign w_match    = (((i_probe0 ^ i_trig_value) & i_trig_mask) == 64'd0);
    assign w_hold_inc = r_hold_cnt + 1'b1;

`ifdef ANALYZER_CAPTURE_EDGE_TRIG_EN
    logic r_prev_match;

    // Reset high so a condition already true out of reset is not treated as a new entry.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) r_prev_match <= 1'b1;
        else            r_prev_match <= w_match;
    end

    assign w_trig = w_match & ~r_prev_match;
`else
    assign w_trig = w_match;
`endif

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vblank_hist <= 1'b1;
            r_frame_cnt   <= '0;
            r_state       <= ST_LIVE;
            r_hold_cnt    <= '0;
            r_debug       <= '0;
            r_shadow      <= '0;
        end else begin
            r_vblank_hist <= i_vblank;
            if (w_fe) r_frame_cnt <= r_frame_cnt + 1'b1;

            case (r_state)
                ST_LIVE: begin
                    if (w_fe)  r_debug <= w_probe;
                    if (i_arm) r_state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_trig) begin
                        r_shadow <= w_probe;
                        if (w_fe) begin
                            // Snapshot and edge coincide: the edge loads the snapshot directly and counts as the first held frame.
                            r_debug    <= w_probe;
                            r_hold_cnt <= HC_W'(1);
                            r_state    <= (HOLD_FRAMES == 0) ? ST_FROZEN : ST_HOLD;
                        end else begin
                            r_hold_cnt <= '0;
                            r_state    <= ST_HOLD;
                        end
                    end else if (w_fe) begin
                        r_debug <= w_probe;
                    end
                end
                ST_HOLD: begin
                    if (w_fe) begin
                        r_hold_cnt <= w_hold_inc;
                        if (r_hold_cnt == '0) r_debug <= r_shadow;
                        if (HOLD_FRAMES == 0)
                            r_state <= ST_FROZEN;
                        else if (w_hold_inc >= HOLD_LIM)
                            r_state <= ST_LIVE;
                    end
                end
                ST_FROZEN: begin
                    if (i_arm) r_state <= ST_ARMED;
                end
                default: r_state <= ST_LIVE;
            endcase
        end
    end

    assign o_debug0    = r_debug[0];
    assign o_debug1    = r_debug[1];
    assign o_debug2    = r_debug[2];
    assign o_debug3    = r_debug[3];
    assign o_debug4    = r_debug[4];
    assign o_debug5    = r_debug[5];
    assign o_debug6    = r_debug[6];
    assign o_debug7    = r_debug[7];
    assign o_state     = r_state;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_analyzer_capture.sv
// Directed bench for analyzer_capture: three instances with HOLD_FRAMES = 3, 0 and 1 share one stimulus stream.
module tb_analyzer_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vblank;
    logic        arm;
    logic [63:0] probe [8];
    logic [63:0] mask;
    logic [63:0] value;

    logic [63:0] d3 [8];
    logic [63:0] d0 [8];
    logic [63:0] d1 [8];
    logic [1:0]  s3, s0, s1;
    logic [15:0] fc3, fc0;
    logic [1:0]  fc1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    analyzer_capture #(.HOLD_FRAMES(3), .FRAME_CNT_W(16)) u_h3 (
        .clk(clk), .i_reset_n(rst_n), .i_vblank(vblank),
        .i_probe0(probe[0]), .i_probe1(probe[1]), .i_probe2(probe[2]), .i_probe3(probe[3]),
        .i_probe4(probe[4]), .i_probe5(probe[5]), .i_probe6(probe[6]), .i_probe7(probe[7]),
        .i_trig_mask(mask), .i_trig_value(value), .i_arm(arm),
        .o_debug0(d3[0]), .o_debug1(d3[1]), .o_debug2(d3[2]), .o_debug3(d3[3]),
        .o_debug4(d3[4]), .o_debug5(d3[5]), .o_debug6(d3[6]), .o_debug7(d3[7]),
        .o_state(s3), .o_frame_cnt(fc3)
    );

    analyzer_capture #(.HOLD_FRAMES(0), .FRAME_CNT_W(16)) u_h0 (
        .clk(clk), .i_reset_n(rst_n), .i_vblank(vblank),
        .i_probe0(probe[0]), .i_probe1(probe[1]), .i_probe2(probe[2]), .i_probe3(probe[3]),
        .i_probe4(probe[4]), .i_probe5(probe[5]), .i_probe6(probe[6]), .i_probe7(probe[7]),
        .i_trig_mask(mask), .i_trig_value(value), .i_arm(arm),
        .o_debug0(d0[0]), .o_debug1(d0[1]), .o_debug2(d0[2]), .o_debug3(d0[3]),
        .o_debug4(d0[4]), .o_debug5(d0[5]), .o_debug6(d0[6]), .o_debug7(d0[7]),
        .o_state(s0), .o_frame_cnt(fc0)
    );

    analyzer_capture #(.HOLD_FRAMES(1), .FRAME_CNT_W(2)) u_h1 (
        .clk(clk), .i_reset_n(rst_n), .i_vblank(vblank),
        .i_probe0(probe[0]), .i_probe1(probe[1]), .i_probe2(probe[2]), .i_probe3(probe[3]),
        .i_probe4(probe[4]), .i_probe5(probe[5]), .i_probe6(probe[6]), .i_probe7(probe[7]),
        .i_trig_mask(mask), .i_trig_value(value), .i_arm(arm),
        .o_debug0(d1[0]), .o_debug1(d1[1]), .o_debug2(d1[2]), .o_debug3(d1[3]),
        .o_debug4(d1[4]), .o_debug5(d1[5]), .o_debug6(d1[6]), .o_debug7(d1[7]),
        .o_state(s1), .o_frame_cnt(fc1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rising vblank edge; outputs are inspected between the two ticks by the caller.
    task automatic vb_rise();
        vblank = 1'b1;
        tick();
    endtask

    task automatic vb_fall();
        vblank = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        vblank = 1'b0;
        arm    = 1'b0;
        for (int i = 0; i < 8; i++) probe[i] = 64'd0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [63:0] any;
        rst_n  = 1'b0;
        vblank = 1'b1;
        arm    = 1'b0;
        mask   = 64'd0;
        value  = 64'd0;
        for (int i = 0; i < 8; i++) probe[i] = 64'hA5A5_0000_0000_0000 + 64'(i);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        any = d3[0] | d3[1] | d3[2] | d3[3] | d3[4] | d3[5] | d3[6] | d3[7];
        total_cnt++;
        if (fc3 !== 16'd0) $display("FAIL reset_frame_cnt got=%0d want=0", fc3);
        else pass_cnt++;
        total_cnt++;
        if (any !== 64'd0) $display("FAIL reset_debug got=%h want=0", any);
        else pass_cnt++;
        total_cnt++;
        if (s3 !== 2'd0) $display("FAIL reset_state got=%0d want=0", s3);
        else pass_cnt++;
        $display("test_reset: frame_cnt=%0d state=%0d", fc3, s3);
    endtask

    task automatic test_live();
        vb_fall();
        probe[3] = 64'hDEADBEEF_01234567;
        vb_rise();
        total_cnt++;
        if (d3[3] !== 64'hDEADBEEF_01234567) $display("FAIL live_capture got=%h want=deadbeef01234567", d3[3]);
        else pass_cnt++;
        total_cnt++;
        if (fc3 !== 16'd1) $display("FAIL live_frame_cnt got=%0d want=1", fc3);
        else pass_cnt++;
        probe[3] = 64'h5555_6666_7777_8888;
        vb_fall();
        tick();
        total_cnt++;
        if (d3[3] !== 64'hDEADBEEF_01234567) $display("FAIL live_stable got=%h want=deadbeef01234567", d3[3]);
        else pass_cnt++;
        vb_rise();
        total_cnt++;
        if (d3[3] !== 64'h5555_6666_7777_8888) $display("FAIL live_next_edge got=%h want=5555666677778888", d3[3]);
        else pass_cnt++;
        vb_fall();
        $display("test_live: debug3=%h frame_cnt=%0d", d3[3], fc3);
    endtask

    task automatic test_armed_hold();
        do_reset();
        mask  = 64'h0000_0000_0000_00FF;
        value = 64'h0000_0000_0000_0042;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        total_cnt++;
        if (s3 !== 2'd1) $display("FAIL armed_state got=%0d want=1", s3);
        else pass_cnt++;
        tick();
        probe[0] = 64'h1142;
        probe[1] = 64'h7;
        tick();
        total_cnt++;
        if (s3 !== 2'd2) $display("FAIL armed_trigger got=%0d want=2", s3);
        else pass_cnt++;
        probe[0] = 64'h99;
        probe[1] = 64'h88;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        total_cnt++;
        if (s3 !== 2'd2) $display("FAIL hold_ignores_arm got=%0d want=2", s3);
        else pass_cnt++;
        vb_rise();
        total_cnt++;
        if (d3[0] !== 64'h1142 || d3[1] !== 64'h7)
            $display("FAIL hold_load got=%h/%h want=1142/7", d3[0], d3[1]);
        else pass_cnt++;
        vb_fall();
        vb_rise();
        total_cnt++;
        if (s3 !== 2'd2 || d3[0] !== 64'h1142) $display("FAIL hold_edge2 got=%0d/%h want=2/1142", s3, d3[0]);
        else pass_cnt++;
        vb_fall();
        vb_rise();
        total_cnt++;
        if (s3 !== 2'd0 || d3[0] !== 64'h1142) $display("FAIL hold_release got=%0d/%h want=0/1142", s3, d3[0]);
        else pass_cnt++;
        vb_fall();
        vb_rise();
        total_cnt++;
        if (d3[0] !== 64'h99 || d3[1] !== 64'h88) $display("FAIL live_resume got=%h/%h want=99/88", d3[0], d3[1]);
        else pass_cnt++;
        vb_fall();
        $display("test_armed_hold: state=%0d debug0=%h debug1=%h", s3, d3[0], d3[1]);
    endtask

    task automatic test_frozen();
        do_reset();
        mask  = 64'h0000_0000_0000_00FF;
        value = 64'h0000_0000_0000_0042;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        probe[0] = 64'h2242;
        probe[5] = 64'hCAFE;
        tick();
        probe[0] = 64'h1;
        probe[5] = 64'h2;
        tick();
        vb_rise();
        total_cnt++;
        if (s0 !== 2'd3 || d0[0] !== 64'h2242 || d0[5] !== 64'hCAFE)
            $display("FAIL frozen_load got=%0d/%h/%h want=3/2242/cafe", s0, d0[0], d0[5]);
        else pass_cnt++;
        vb_fall();
        for (int i = 0; i < 5; i++) begin
            vb_rise();
            vb_fall();
        end
        total_cnt++;
        if (s0 !== 2'd3 || d0[0] !== 64'h2242 || d0[5] !== 64'hCAFE)
            $display("FAIL frozen_stable got=%0d/%h/%h want=3/2242/cafe", s0, d0[0], d0[5]);
        else pass_cnt++;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        total_cnt++;
        if (s0 !== 2'd1) $display("FAIL frozen_rearm got=%0d want=1", s0);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (s0 !== 2'd0 || d0[0] !== 64'd0 || fc0 !== 16'd0)
            $display("FAIL async_reset got=%0d/%h/%0d want=0/0/0", s0, d0[0], fc0);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        $display("test_frozen: state=%0d debug0=%h", s0, d0[0]);
    endtask

    task automatic test_coincident();
        do_reset();
        mask  = 64'h0000_0000_0000_00FF;
        value = 64'h0000_0000_0000_0042;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        probe[0] = 64'hAB42;
        probe[2] = 64'h3;
        vb_rise();
        total_cnt++;
        if (s1 !== 2'd2 || d1[0] !== 64'hAB42 || d1[2] !== 64'h3)
            $display("FAIL coincident_load got=%0d/%h/%h want=2/ab42/3", s1, d1[0], d1[2]);
        else pass_cnt++;
        probe[0] = 64'h11;
        probe[2] = 64'h12;
        vb_fall();
        vb_rise();
        total_cnt++;
        if (s1 !== 2'd0 || d1[0] !== 64'hAB42) $display("FAIL coincident_release got=%0d/%h want=0/ab42", s1, d1[0]);
        else pass_cnt++;
        vb_fall();
        vb_rise();
        total_cnt++;
        if (d1[0] !== 64'h11 || d1[2] !== 64'h12) $display("FAIL coincident_live got=%h/%h want=11/12", d1[0], d1[2]);
        else pass_cnt++;
        vb_fall();
        vb_rise();
        total_cnt++;
        if (fc1 !== 2'd0) $display("FAIL frame_cnt_wrap got=%0d want=0", fc1);
        else pass_cnt++;
        vb_fall();
        $display("test_coincident: state=%0d debug0=%h frame_cnt=%0d", s1, d1[0], fc1);
    endtask

    task automatic test_edge_trig();
        logic [1:0] exp_first;
`ifdef ANALYZER_CAPTURE_EDGE_TRIG_EN
        exp_first = 2'd1;
`else
        exp_first = 2'd2;
`endif
        do_reset();
        mask     = 64'h0000_0000_0000_00FF;
        value    = 64'h0000_0000_0000_0042;
        probe[0] = 64'h42;
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        total_cnt++;
        if (s3 !== exp_first) $display("FAIL trig_at_arm got=%0d want=%0d", s3, exp_first);
        else pass_cnt++;
        probe[0] = 64'h0;
        tick();
        probe[0] = 64'h42;
        tick();
        total_cnt++;
        if (s3 !== 2'd2) $display("FAIL trig_reassert got=%0d want=2", s3);
        else pass_cnt++;
        $display("test_edge_trig: state=%0d", s3);
    endtask

    initial begin
        test_reset();
        test_live();
        test_armed_hold();
        test_frozen();
        test_coincident();
        test_edge_trig();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/analyzer_capture.md
Name: analyzer_capture

Overview:
- Upstream feeder for the on-screen debug hex overlay. It samples eight 64-bit probe buses and presents them as eight stable debug words.
- Output words change only on a frame boundary (vblank rising edge), so the overlay never tears mid-frame.
- Provides an arm/trigger/hold mechanism: the display can freeze on the frame where probe 0 matches a masked pattern.

Parameters:
HOLD_FRAMES, 60, number of vblank edges a triggered snapshot is held before returning to live; 0 = hold until re-armed
FRAME_CNT_W, 16, width of free-running frame counter

Ports:
clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_vblank  in  1  vertical blank, synchronous to clk
i_probe0..i_probe7  in  64 each  live debug probe buses
i_trig_mask  in  64  bit mask applied to i_probe0 for trigger compare
i_trig_value  in  64  compare value for trigger
i_arm  in  1  single-cycle pulse, arms trigger
o_debug0..o_debug7  out  64 each  frame-stable debug words to the overlay
o_state  out  2  0=LIVE, 1=ARMED, 2=HOLD, 3=FROZEN
o_frame_cnt  out  FRAME_CNT_W  count of vblank rising edges

Behaviour:
- Reset is asynchronous, active-low:
  - all o_debugN = 0, o_state = LIVE, o_frame_cnt = 0, hold counter = 0, shadow registers = 0
  - vblank history register = 1, so no spurious edge is seen when i_vblank is high at release.
- Frame edge (fe) = i_vblank high and history low, registered one clock. On fe, o_frame_cnt increments and wraps modulo 2^FRAME_CNT_W.
- match = ((i_probe0 ^ i_trig_value) & i_trig_mask) == 0, evaluated combinationally each clock. An all-zero mask matches always.
- LIVE:
  - on fe, o_debugN <= i_probeN sampled on that cycle; visible the next cycle (1-clock latency).
  - i_arm -> ARMED next cycle.
- ARMED:
  - fe behaves as in LIVE.
  - match on a clock: all eight probes are copied into shadow on that cycle; state -> HOLD; hold counter = 0.
  - A match on the same cycle as i_arm entry is not evaluated; compare starts the cycle after entry.
- HOLD:
  - no further captures.
  - first fe after entry: o_debugN <= shadowN, hold counter = 1.
  - each subsequent fe: counter increments, outputs unchanged.
  - when counter reaches HOLD_FRAMES on an fe: state -> LIVE; live sampling resumes at the next fe, not the same one.
  - HOLD_FRAMES = 0: after the first fe load, go to FROZEN instead.
- FROZEN: outputs unchanged indefinitely; i_arm -> ARMED.
- i_arm in HOLD: ignored. Repeated i_arm in ARMED: no effect.
- Trigger match on the same cycle as fe in ARMED: the snapshot is captured, and that fe loads o_debugN from the snapshot (bypass), counted as the first HOLD fe (hold counter = 1).
- o_state reflects the registered state.
- Outputs never change except on fe or reset.
- Reset asserted mid-hold: immediate return to reset values.

Optional Feature:
- Macro ANALYZER_CAPTURE_EDGE_TRIG_EN.
- Defined: adds a registered prev_match, reset 1. Trigger fires only when match is high and prev_match is low, i.e. on entry into the matching condition. A condition already true when armed does not fire until it drops and reasserts. prev_match updates every clock in all states.
- Undefined: level trigger as described above; no prev_match register.

Test Plan:
- Reset with i_vblank=1, release, hold i_vblank=1 for 10 clocks -> no fe; o_frame_cnt=0; all o_debugN=0; o_state=0.
- LIVE: i_probe3=64'hDEADBEEF_01234567, pulse vblank 0->1, then change probe -> o_debug3 = DEADBEEF_01234567 one clock after the edge and stable until the next edge; o_frame_cnt=1.
- ARMED: mask=64'hFF, value=64'h42; i_probe0 steps to 64'h1142 mid-frame with i_probe1=7, then probes change -> state=2; next fe gives o_debug0=1142, o_debug1=7; held for HOLD_FRAMES=3 edges; LIVE after the 3rd; live values appear on the 4th edge.
- HOLD_FRAMES=0: trigger -> snapshot loads on the first fe, o_state=3; 5 further edges leave outputs unchanged; i_arm -> o_state=1.
- Trigger coincident with fe -> that edge loads the snapshot; hold counter=1; with HOLD_FRAMES=1, state returns to LIVE on the next fe.
- With ANALYZER_CAPTURE_EDGE_TRIG_EN: match already true at arm -> no trigger; drop for 1 clock, reassert -> trigger. Without the macro, the same stimulus triggers on the first cycle after arm.
